fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//   Single-clock, parametrised FIFO for the FIR datapath: buffers samples between producer and
//   consumer stages on the same clock. Generalises the fixed 32x128 FIFO: width/depth set by
//   parameters, run-time reserve threshold, non-advancing "nap" reads, occupancy output, and
//   sticky overflow/underflow flags.
// PARAMETERS
//   DATA_WIDTH  32  data word width in bits
//   ADDR_WIDTH  7   log2(depth); DEPTH = 2**ADDR_WIDTH entries
// PORTS
//   clk          in   1             clock, all state updates on posedge
//   reset        in   1             asynchronous, active-high reset
//   data_in      in   DATA_WIDTH    write data
//   wr_valid     in   1             write strobe; word is taken when wr_valid & !full
//   wr_request   out  1             space available beyond reserve; producer may write
//   full         out  1             count == DEPTH
//   reserve      in   ADDR_WIDTH    entries held back from wr_request (quasi-static)
//   rd_request   in   1             read strobe; honoured when !empty
//   nap          in   1             with rd_request: output head word, do not pop
//   data_out     out  DATA_WIDTH    registered read data
//   rd_valid     out  1             one-cycle pulse: data_out updated this cycle
//   empty        out  1             count == 0
//   fifo_util    out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//   overflow     out  1             sticky: write attempted while full
//   underflow    out  1             sticky: read attempted while empty
//   clear_err    in   1             synchronous clear of overflow/underflow
// BEHAVIOUR
//   - Pointers wr_ptr/rd_ptr are ADDR_WIDTH+1 bits; wrap modulo 2*DEPTH; count = wr_ptr - rd_ptr.
//   - Reset (async assert): pointers 0, data_out 0, rd_valid 0, wr_request 0, overflow 0,
//     underflow 0; hence empty 1, full 0, fifo_util 0. Memory contents are not reset.
//   - Write: wr_valid & !full -> mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in, wr_ptr++.
//     wr_valid & full -> word dropped, overflow <= 1.
//   - Read: rd_request & !empty -> data_out <= head word at next edge (1-cycle latency),
//     rd_valid <= 1; rd_ptr++ unless nap=1. rd_request & empty -> data_out holds, rd_valid 0,
//     underflow <= 1. rd_valid is 0 in every cycle without an honoured read.
//   - Full/empty decisions use the registered count at the edge (no bypass):
//     empty + simultaneous write and read -> write accepted, read is underflow.
//     full + simultaneous write and popping read -> both accepted, count unchanged.
//     full + write + nap read -> write dropped (overflow), nap read honoured.
//   - wr_request is registered: wr_request <= (DEPTH - count_next) > reserve. First cycle after
//     reset release it rises to 1 if reserve < DEPTH. reserve >= DEPTH forces wr_request 0;
//     writes are still accepted up to full.
//   - empty, full, fifo_util are combinational from registered pointers only.
//   - clear_err=1 clears overflow/underflow; a same-cycle new error wins (flag stays set).
//   - Reset mid-operation: all stored words discarded; behaviour identical to power-up.
// STRUCTURE
//   - fifo_pkg: default DATA_WIDTH/ADDR_WIDTH localparams, shared with FIR stages.
//   - Sub-module fifo_ram: DEPTH x DATA_WIDTH register array, one write port, one synchronous
//     read port; the top level holds pointers, flags, and wr_request logic.
// TESTING
//   1. Reset, then write 0x1..0x4 (one per cycle), then read 4 -> data_out 1,2,3,4 each one
//      cycle after its rd_request; rd_valid high 4 cycles; empty=1, fifo_util=0 at end.
//   2. ADDR_WIDTH=3, reserve=2: write 6 words -> wr_request falls once fifo_util=6; writes 7, 8
//      still accepted -> full=1; 9th write -> overflow=1, fifo_util stays 8.
//   3. Empty FIFO, rd_request=1 -> underflow=1, rd_valid=0, data_out unchanged; clear_err ->
//      underflow=0 next cycle.
//   4. Full FIFO, wr_valid & rd_request same cycle -> fifo_util stays DEPTH, data order
//      preserved, overflow stays 0.
//   5. Head 0xA5: rd_request+nap x3 -> data_out 0xA5 three times, fifo_util unchanged;
//      then plain read -> 0xA5 again and fifo_util decrements.
//   6. Stream >2*DEPTH words with random valid/request gaps -> ascending data, no errors;
//      assert reset mid-stream -> empty=1, wr_request=0 immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: default FIFO geometry shared by the FIR datapath stages.
package fifo_pkg;
  localparam int FIFO_DATA_WIDTH = 32;
  localparam int FIFO_ADDR_WIDTH = 7;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_WIDTH storage, one write port and one registered read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  // A same-edge write to the read slot (full FIFO, write + pop) returns the old head.
  always_comb rdata_d = re ? mem_q[raddr] : rdata_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with reserve threshold, nap reads, occupancy and sticky errors.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_valid,
  output logic                  wr_request,
  output logic                  full,
  input  logic [ADDR_WIDTH-1:0] reserve,
  input  logic                  rd_request,
  input  logic                  nap,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   fifo_util,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_err
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count, count_d, space_d;
  logic wr_en, rd_en, pop;
  logic wr_request_q, wr_request_d, rd_valid_q, rd_valid_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  // A popping read frees the slot in the same edge, so a full FIFO still takes the write.
  always_comb begin
    count        = wr_ptr_q - rd_ptr_q;
    empty        = count == '0;
    full         = count == DEPTH_C;
    rd_en        = rd_request & !empty;
    pop          = rd_en & !nap;
    wr_en        = wr_valid & (!full | pop);
    wr_ptr_d     = wr_en ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + ONE : rd_ptr_q;
    count_d      = wr_ptr_d - rd_ptr_d;
    space_d      = DEPTH_C - count_d;
    wr_request_d = space_d > {1'b0, reserve};
    rd_valid_d   = rd_en;
    overflow_d   = (overflow_q & !clear_err) | (wr_valid & !wr_en);
    underflow_d  = (underflow_q & !clear_err) | (rd_request & empty);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wr_request_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_request_q <= wr_request_d;
      rd_valid_q   <= rd_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end
  fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (data_in),
    .re    (rd_en),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (data_out)
  );
  assign fifo_util  = count;
  assign wr_request = wr_request_q;
  assign rd_valid   = rd_valid_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed and randomized checks of fifo_sync_param against a queue model.
module tb_fifo_sync_param;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  logic clk = 0;
  logic reset = 1;
  logic [DW-1:0] data_in = '0;
  logic wr_valid = 0, rd_request = 0, nap = 0, clear_err = 0;
  logic [AW-1:0] reserve = '0;
  logic wr_request, full, rd_valid, empty, overflow, underflow;
  logic [DW-1:0] data_out;
  logic [AW:0] fifo_util;
  int total = 0;
  int bad = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic m_rv, m_ovf, m_unf, m_wrq;
  fifo_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .wr_valid(wr_valid),
    .wr_request(wr_request), .full(full), .reserve(reserve),
    .rd_request(rd_request), .nap(nap), .data_out(data_out),
    .rd_valid(rd_valid), .empty(empty), .fifo_util(fifo_util),
    .overflow(overflow), .underflow(underflow), .clear_err(clear_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".empty"}, DW'(empty), DW'(q.size() == 0));
    chk({tag, ".full"}, DW'(full), DW'(q.size() == DEPTH));
    chk({tag, ".util"}, DW'(fifo_util), DW'(q.size()));
    chk({tag, ".rd_valid"}, DW'(rd_valid), DW'(m_rv));
    chk({tag, ".data_out"}, data_out, m_dout);
    chk({tag, ".overflow"}, DW'(overflow), DW'(m_ovf));
    chk({tag, ".underflow"}, DW'(underflow), DW'(m_unf));
    chk({tag, ".wr_request"}, DW'(wr_request), DW'(m_wrq));
  endtask
  task automatic do_reset(input string tag);
    wr_valid = 0; rd_request = 0; nap = 0; clear_err = 0;
    reset = 1;
    #1;
    q.delete();
    m_dout = '0; m_rv = 0; m_ovf = 0; m_unf = 0; m_wrq = 0;
    check_all(tag);
    @(negedge clk);
    reset = 0;
  endtask
  task automatic step(input logic wv, input logic [DW-1:0] din, input logic rr,
                      input logic np, input logic ce, input string tag);
    int n;
    bit rd_ok, pop_m, wr_ok;
    wr_valid = wv; data_in = din; rd_request = rr; nap = np; clear_err = ce;
    @(posedge clk);
    n = q.size();
    rd_ok = rr && n > 0;
    pop_m = rd_ok && !np;
    wr_ok = wv && (n < DEPTH || pop_m);
    m_rv = rd_ok;
    if (rd_ok) m_dout = q[0];
    if (pop_m) void'(q.pop_front());
    if (wr_ok) q.push_back(din);
    m_ovf = (m_ovf && !ce) || (wv && !wr_ok);
    m_unf = (m_unf && !ce) || (rr && n == 0);
    m_wrq = (DEPTH - q.size()) > int'(reserve);
    #1;
    check_all(tag);
  endtask
  initial begin
    int wrote;
    int target;
    bit wv, rr;
    do_reset("reset");
    step(0, 0, 0, 0, 0, "idle");
    for (int i = 1; i <= 4; i++) step(1, DW'(i), 0, 0, 0, "t1_wr");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, "t1_rd");
    step(0, 0, 0, 0, 0, "t1_end");
    reserve = 3'd2;
    for (int i = 1; i <= 8; i++) step(1, DW'(32'h20 + i), 0, 0, 0, "t2_wr");
    step(1, 32'hdead, 0, 0, 0, "t2_ovf");
    step(0, 0, 0, 0, 1, "t2_clr");
    reserve = 3'd0;
    step(1, 32'h31, 1, 0, 0, "t4_wr_pop");
    step(1, 32'h32, 1, 0, 0, "t4_wr_pop2");
    step(1, 32'h33, 1, 1, 0, "t4_wr_nap");
    step(0, 0, 0, 0, 1, "t4_clr");
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, "t4_drain");
    step(0, 0, 1, 0, 0, "t3_unf");
    step(0, 0, 0, 0, 1, "t3_clr");
    step(1, 32'ha5, 1, 0, 1, "t3_clr_vs_new");
    step(0, 0, 0, 0, 1, "t3_clr2");
    step(1, 32'h5a, 0, 0, 0, "t5_wr");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, "t5_nap");
    step(0, 0, 1, 0, 0, "t5_pop");
    step(0, 0, 1, 0, 0, "t5_pop2");
    reserve = 3'd7;
    step(0, 0, 0, 0, 0, "t6_rsv7");
    step(1, 32'h77, 0, 0, 0, "t6_rsv7_wr");
    step(0, 0, 1, 0, 0, "t6_rsv7_rd");
    reserve = AW'($urandom_range(0, 6));
    wrote = 0;
    target = 3 * DEPTH;
    while (wrote < target || q.size() > 0) begin
      wv = wrote < target && q.size() < DEPTH && ($urandom_range(0, 3) != 0);
      rr = q.size() > 0 && ($urandom_range(0, 2) != 0);
      step(wv, DW'(32'h100 + wrote), rr, 0, 0, "t6_stream");
      if (wv) wrote++;
      if (wrote == 11 && q.size() > 1) begin
        @(posedge clk);
        #1;
        do_reset("t6_midreset");
      end
    end
    step(0, 0, 0, 0, 0, "t6_end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
